serial_subtractor: RTL

//   Bit-serial, LSB-first W-bit subtractor: computes A - B - borrow_in with one
//   1-bit full-subtractor cell and a registered borrow, one bit per clock.

---
 rtl/serial_arith_pkg.sv | 12 +
 rtl/full_subtractor_cell.sv | 19 +
 rtl/serial_subtractor.sv | 104 ++++++++++
 3 files changed

// File: rtl/serial_arith_pkg.sv
// Shared encodings and default width for the bit-serial arithmetic units.
package serial_arith_pkg;

    localparam int unsigned SER_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: d = x - y - bin, with borrow out.
module full_subtractor_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic x_xor_y;

    always_comb begin
        x_xor_y = x ^ y;
        d       = x_xor_y ^ bin;
        // Borrow when x=0,y=1, or when x==y and a borrow ripples through.
        bout    = (~x & y) | (~x_xor_y & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first W-bit subtractor with a start/busy/done handshake.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int unsigned W = SER_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         borrow_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         borrow_out,
    output logic         bit_valid,
    output logic         bit_out
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LastCount = CW'(W - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] count_q;
    logic [W-1:0]  sa_q, sb_q, sd_q, diff_q;
    logic          br_q, borrow_out_q, bit_valid_q, bit_out_q;
    logic          cell_d, cell_bo;
    logic          in_run, accept, last;

    full_subtractor_cell u_cell (
        .x    (sa_q[0]),
        .y    (sb_q[0]),
        .bin  (br_q),
        .d    (cell_d),
        .bout (cell_bo)
    );

    assign in_run = (state_q == ST_RUN);
    // IDLE and DONE both accept; a start during RUN is dropped.
    assign accept = start && !in_run;
    assign last   = in_run && (count_q == LastCount);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (last)  state_d = ST_DONE;
            ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q      <= '0;
            sa_q         <= '0;
            sb_q         <= '0;
            sd_q         <= '0;
            br_q         <= 1'b0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            bit_valid_q  <= 1'b0;
            bit_out_q    <= 1'b0;
        end else begin
            bit_valid_q <= in_run;
            if (in_run) begin
                br_q      <= cell_bo;
                sa_q      <= sa_q >> 1;
                sb_q      <= sb_q >> 1;
                sd_q      <= {cell_d, sd_q[W-1:1]};
                count_q   <= count_q + 1'b1;
                bit_out_q <= cell_d;
            end
            // Result registers only move on the final RUN edge.
            if (last) begin
                diff_q       <= {cell_d, sd_q[W-1:1]};
                borrow_out_q <= cell_bo;
            end
            if (accept) begin
                sa_q    <= a;
                sb_q    <= b;
                br_q    <= borrow_in;
                count_q <= '0;
            end
        end
    end

    assign busy       = in_run;
    assign done       = (state_q == ST_DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;
    assign bit_valid  = bit_valid_q;
    assign bit_out    = bit_out_q;

endmodule
